// File: rtl/caliptra_prim_cnt_pkg.sv
// Shared types and helpers for the hardened counter. The counter command is
// decoded once and the same decoded value steers both redundant copies.
package caliptra_prim_cnt_pkg;

   // Decoded per-cycle command, listed in priority order after CntHold.
   typedef enum logic [2:0] {
      CntHold = 3'd0,
      CntClr  = 3'd1,
      CntSet  = 3'd2,
      CntIncr = 3'd3,
      CntDecr = 3'd4
   } cnt_cmd_e;

   // clr beats set, and set beats counting. When incr and decr are both high
   // they cancel, so the counter holds.
   function automatic cnt_cmd_e decode_cmd(input logic clr,
                                           input logic set,
                                           input logic incr,
                                           input logic decr);
      cnt_cmd_e cmd;
      cmd = CntHold;
      if (clr) begin
         cmd = CntClr;
      end else if (set) begin
         cmd = CntSet;
      end else if (incr && !decr) begin
         cmd = CntIncr;
      end else if (decr && !incr) begin
         cmd = CntDecr;
      end
      return cmd;
   endfunction

endpackage

// File: rtl/caliptra_prim_hardened_cnt_nxt.sv
// Next-state logic for one copy of the hardened counter. The up copy tracks
// the count itself. The down copy tracks MaxVal minus the count, so each
// command moves it in the opposite direction. Only this copy's own register
// feeds the computation.
module caliptra_prim_hardened_cnt_nxt
   import caliptra_prim_cnt_pkg::*;
#(
   parameter int unsigned      Width    = 8,
   parameter bit               Up       = 1'b1,
   parameter logic [Width-1:0] ClrValue = '0
) (
   input  cnt_cmd_e         cmd_i,
   input  logic [Width-1:0] q_i,
   input  logic [Width-1:0] set_cnt_i,
   input  logic [Width-1:0] step_i,
   output logic [Width-1:0] d_o
);

   localparam logic [Width-1:0] MaxVal = {Width{1'b1}};

   // Add with one extra bit of headroom. A carry clamps the result to MaxVal.
   function automatic logic [Width-1:0] sat_add(input logic [Width-1:0] a,
                                                input logic [Width-1:0] b);
      logic [Width:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[Width] ? MaxVal : sum[Width-1:0];
   endfunction

   // Subtract with one extra bit. A borrow clamps the result to zero.
   function automatic logic [Width-1:0] sat_sub(input logic [Width-1:0] a,
                                                input logic [Width-1:0] b);
      logic [Width:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      return diff[Width] ? '0 : diff[Width-1:0];
   endfunction

   // Select this copy's next value from the decoded command.
   always_comb begin
      d_o = q_i;
      case (cmd_i)
         CntClr:  d_o = ClrValue;
         CntSet:  d_o = Up ? set_cnt_i : (MaxVal - set_cnt_i);
         CntIncr: d_o = Up ? sat_add(q_i, step_i) : sat_sub(q_i, step_i);
         CntDecr: d_o = Up ? sat_sub(q_i, step_i) : sat_add(q_i, step_i);
         default: d_o = q_i;
      endcase
   end

endmodule

// File: rtl/caliptra_prim_sec_anchor_flop.sv
// Storage flop for security-relevant state. It is a separate module so that
// synthesis keeps each instance distinct and does not merge the redundant
// copies.
module caliptra_prim_sec_anchor_flop #(
   parameter int unsigned           Width      = 1,
   parameter logic [Width-1:0]      ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   // Plain register with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_o <= ResetValue;
      end else begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/caliptra_prim_hardened_cnt.sv
// Fault-hardened saturating counter. It keeps an up-count copy and a
// complementary down-count copy in separate anchor flops. Whenever the two
// copies do not sum to MaxVal, a glitch or fault has hit one of them, and the
// counter raises err_o. The counter keeps running after an error, and the
// consumer decides how to escalate.
module caliptra_prim_hardened_cnt
   import caliptra_prim_cnt_pkg::*;
#(
   parameter int unsigned Width            = 8,
   parameter int unsigned ResetValue       = 0,
   parameter bit          EnableAlertLatch = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             set_i,
   input  logic [Width-1:0] set_cnt_i,
   input  logic             incr_en_i,
   input  logic             decr_en_i,
   input  logic [Width-1:0] step_i,
   output logic [Width-1:0] cnt_o,
   output logic [Width-1:0] cnt_after_commit_o,
   output logic             err_o
);

   localparam logic [Width-1:0] MaxVal    = {Width{1'b1}};
   localparam logic [Width:0]   MaxValExt = {1'b0, MaxVal};
   localparam logic [Width-1:0] UpRstVal  = Width'(ResetValue);
   localparam logic [Width-1:0] DnRstVal  = MaxVal - UpRstVal;

   // Parameter sanity checks at elaboration time.
   if (Width < 2) begin : gen_width_chk
      $error("caliptra_prim_hardened_cnt: Width must be at least 2");
   end
   if (64'(ResetValue) > ((64'd1 << Width) - 64'd1)) begin : gen_rst_val_chk
      $error("caliptra_prim_hardened_cnt: ResetValue exceeds MaxVal");
   end

   cnt_cmd_e         cmd;
   logic [Width-1:0] up_q, up_d;
   logic [Width-1:0] dn_q, dn_d;
   logic [Width:0]   pair_sum;
   logic             mismatch;
   logic             err_q, err_d;

   assign cmd = decode_cmd(clr_i, set_i, incr_en_i, decr_en_i);

   // The two copies use independent next-state instances. Neither copy is
   // derived from the other.
   caliptra_prim_hardened_cnt_nxt #(
      .Width    (Width),
      .Up       (1'b1),
      .ClrValue (UpRstVal)
   ) u_up_nxt (
      .cmd_i     (cmd),
      .q_i       (up_q),
      .set_cnt_i (set_cnt_i),
      .step_i    (step_i),
      .d_o       (up_d)
   );

   caliptra_prim_hardened_cnt_nxt #(
      .Width    (Width),
      .Up       (1'b0),
      .ClrValue (DnRstVal)
   ) u_dn_nxt (
      .cmd_i     (cmd),
      .q_i       (dn_q),
      .set_cnt_i (set_cnt_i),
      .step_i    (step_i),
      .d_o       (dn_d)
   );

   caliptra_prim_sec_anchor_flop #(
      .Width      (Width),
      .ResetValue (UpRstVal)
   ) u_up_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (up_d),
      .q_o    (up_q)
   );

   caliptra_prim_sec_anchor_flop #(
      .Width      (Width),
      .ResetValue (DnRstVal)
   ) u_dn_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (dn_d),
      .q_o    (dn_q)
   );

   // The copies must always sum to MaxVal. The sum carries an extra bit so
   // that an overflowing pair can never alias to MaxVal.
   assign pair_sum = {1'b0, up_q} + {1'b0, dn_q};
   assign mismatch = (pair_sum != MaxValExt);

   // Once err_q is set it stays set. Only rst_ni clears it; clr and set do not.
   assign err_d = err_q | mismatch;

   caliptra_prim_sec_anchor_flop #(
      .Width      (1),
      .ResetValue (1'b0)
   ) u_err_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (err_d),
      .q_o    (err_q)
   );

   assign cnt_o              = up_q;
   assign cnt_after_commit_o = up_d;
   assign err_o              = EnableAlertLatch ? (err_q | mismatch) : mismatch;

   // A consistent state must lead to a consistent next state.
   AssertNextConsistent: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !mismatch |-> (({1'b0, up_d} + {1'b0, dn_d}) == MaxValExt));

   // A clear lands ResetValue on the output one cycle later.
   AssertClrLoads: assert property (@(posedge clk_i) disable iff (!rst_ni)
      clr_i |=> (cnt_o == UpRstVal));

   // A set without clear lands set_cnt_i on the output one cycle later.
   AssertSetLoads: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (set_i && !clr_i) |=> (cnt_o == $past(set_cnt_i)));

endmodule
